// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: launches one memory fetch per PC, stalls the PC
// generator while it is outstanding, and returns the instruction as a one-cycle strobe.
module inst_fetch_resp #(
  parameter int ADDR_W  = 17,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_i,
  input  logic [31:0]       pc_i,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [31:0]       inst_o,
  output logic [31:0]       inst_pc_o,
  output logic              inst_valid_o,
  output logic              fetch_err_o,
  output logic              stallreq_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [7:0]  cnt_q;
  logic        drop_q;

  logic timeout_hit, launch, misalign, ack_done, abort;

  // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    timeout_hit = (state_q == BUSY) && (cnt_q == CNT_LAST);
    launch      = (state_q == IDLE) && ce_i && !flush_i && (pc_i[1:0] == 2'b00);
    misalign    = (state_q == IDLE) && ce_i && !flush_i && (pc_i[1:0] != 2'b00);
    ack_done    = (state_q == BUSY) && mem_ack_i;
    abort       = timeout_hit && !mem_ack_i;
    case (state_q)
      IDLE:    if (launch) state_d = BUSY;
      BUSY:    if (ack_done || abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Low on the ack cycle so the PC advances on the same edge the data is captured.
    stallreq_o = (state_q == BUSY) && !mem_ack_i && !timeout_hit;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      drop_q       <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      inst_o       <= '0;
      inst_pc_o    <= '0;
      inst_valid_o <= 1'b0;
      fetch_err_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_valid_o <= 1'b0;
      fetch_err_o  <= 1'b0;

      if (launch) begin
        addr_q     <= pc_i;
        mem_req_o  <= 1'b1;
        mem_addr_o <= pc_i[ADDR_W+1:2];
        cnt_q      <= '0;
        drop_q     <= 1'b0;
      end

      if (misalign) begin
        inst_valid_o <= 1'b1;
        fetch_err_o  <= 1'b1;
        inst_o       <= '0;
        inst_pc_o    <= pc_i;
      end

      if (state_q == BUSY) begin
        cnt_q <= cnt_q + 8'd1;
        if (ack_done) begin
          mem_req_o <= 1'b0;
          drop_q    <= 1'b0;
          cnt_q     <= '0;
          if (!drop_q && !flush_i) begin
            inst_valid_o <= 1'b1;
            inst_o       <= mem_rdata_i;
            inst_pc_o    <= addr_q;
          end
        end else if (abort) begin
          mem_req_o <= 1'b0;
          drop_q    <= 1'b0;
          cnt_q     <= '0;
          if (!drop_q) begin
            inst_valid_o <= 1'b1;
            fetch_err_o  <= 1'b1;
            inst_o       <= '0;
            inst_pc_o    <= addr_q;
          end
        end else if (flush_i) begin
          // Request stays open; the eventual data is discarded.
          drop_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/inst_fetch_resp.md
Name: inst_fetch_resp

Overview:
Instruction-side responder for the PC generator: consumes pc/ce and returns the instruction at that address. Runs a req/ack handshake with the instruction memory, holds the PC generator through stallreq_o while a fetch is outstanding, and drops in-flight fetches on branch flush. Sits between the PC register/stall controller and instruction ROM/bus, feeding the IF/ID stage.

Parameters:
ADDR_W, 17, word-address width driven to memory (byte address bits [ADDR_W+1:2]).
TIMEOUT, 16, cycles in BUSY without mem_ack_i before the fetch aborts with error; legal range 2..255.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
ce_i  input  1  fetch enable from the PC generator.
pc_i  input  32  byte address to fetch.
flush_i  input  1  branch taken / pipeline flush; discards the outstanding fetch.
mem_req_o  output  1  memory request; held high until mem_ack_i.
mem_addr_o  output  ADDR_W  word address, pc[ADDR_W+1:2] of the captured PC.
mem_rdata_i  input  32  instruction data; valid when mem_ack_i=1.
mem_ack_i  input  1  one-cycle completion strobe from memory.
inst_o  output  32  fetched instruction; 32'h0 (NOP) when no valid fetch.
inst_pc_o  output  32  byte PC of inst_o.
inst_valid_o  output  1  one-cycle strobe: inst_o/inst_pc_o valid.
fetch_err_o  output  1  one-cycle strobe with inst_valid_o: misaligned PC or timeout; inst_o=0.
stallreq_o  output  1  stall request to the stall controller (freezes PC).

Behaviour:
- Reset (asynchronous, any state, including mid-fetch): state=IDLE, mem_req_o=0, mem_addr_o=0, inst_o=0, inst_pc_o=0, inst_valid_o=0, fetch_err_o=0, drop flag=0, counter=0. A mem_ack_i arriving after reset is ignored.
- States: IDLE, BUSY.
- IDLE, ce_i=0: no action; all strobes 0.
- IDLE, ce_i=1, pc_i[1:0]==0, flush_i=0: capture pc_i into addr_q; next cycle BUSY with mem_req_o=1, mem_addr_o=pc_i[ADDR_W+1:2], counter=0.
- IDLE, ce_i=1, pc_i[1:0]!=0, flush_i=0: no memory request. Next cycle inst_valid_o=1, fetch_err_o=1, inst_o=0, inst_pc_o=pc_i. Stay IDLE.
- IDLE with flush_i=1: no launch this cycle.
- BUSY: mem_req_o and mem_addr_o are stable until the ack or the abort. Counter increments each cycle.
- BUSY, mem_ack_i=1: mem_req_o=0 next cycle; state goes to IDLE.
  - If drop=0 and flush_i=0: next cycle inst_o=mem_rdata_i, inst_pc_o=addr_q, inst_valid_o=1.
  - Otherwise the data is discarded and inst_valid_o stays 0.
  - drop clears.
- BUSY, flush_i=1 without ack: drop<=1 and the handshake is held open to completion. A memory request is never withdrawn early, except on timeout.
- BUSY, counter==TIMEOUT-1 and no ack: mem_req_o=0 and state goes to IDLE. Next cycle inst_valid_o=1, fetch_err_o=1, inst_o=0, inst_pc_o=addr_q. If drop=1, no strobe is emitted. A stray late ack in IDLE is ignored.
- Ack and timeout on the same cycle: ack wins.
- stallreq_o is combinational: (state==BUSY) & ~mem_ack_i & ~timeout_hit. It is therefore low on the ack cycle, so the PC advances on that edge.
- Fetch launch latency: 1 cycle after ce_i/pc_i. Fetch result latency: 1 cycle after mem_ack_i. Throughput: one bubble cycle between fetches (IDLE re-launch).
- inst_valid_o and fetch_err_o are single-cycle. inst_o and inst_pc_o hold their last value when valid is low.
- Counter width: 8 bits; it does not wrap below TIMEOUT.

Test Plan:
- Reset then ce_i=1, pc_i=0x0, memory acks 2 cycles after the request with 0x3C010001 -> mem_addr_o=0; stallreq_o high for 2 cycles, low on the ack cycle; next cycle inst_valid_o=1, inst_o=0x3C010001, inst_pc_o=0.
- Back-to-back fetches of 0x0, 0x4, 0x8 with a zero-wait memory (ack the cycle after req) -> mem_addr_o=0,1,2; three inst_valid_o strobes spaced 2 cycles apart, in order.
- pc_i=0x6 with ce_i=1 -> mem_req_o never asserts; one cycle later inst_valid_o=1, fetch_err_o=1, inst_o=0, inst_pc_o=0x6.
- Fetch 0x10, memory never acks, TIMEOUT=16 -> mem_req_o high exactly 16 cycles, then fetch_err_o=1 with inst_pc_o=0x10; a late ack 3 cycles later produces no strobe.
- Fetch 0x20, flush_i pulsed 1 cycle before an ack carrying 0xDEADBEEF -> mem_req_o held until the ack; inst_valid_o stays 0; the next launch uses the new pc_i (e.g. branch target 0x100, mem_addr_o=0x40).
- reset asserted mid-BUSY, then the ack arrives while reset is high -> all outputs 0 immediately; no strobe after reset releases.
